// File: rtl/dual_port_bytelane_ram.sv
// True dual-port byte-lane RAM with selectable read-during-write, optional
// output register stage and a zeroing sequencer run after reset or on request.
module dual_port_bytelane_ram #(
  parameter int bitwidth       = 32,
  parameter int nrOfEntries    = 512,
  parameter int readMode       = 0,
  parameter int outputRegister = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clearRequest,
  output logic                           busy,
  input  logic                           requestA,
  input  logic                           writeEnableA,
  input  logic [bitwidth/8-1:0]          byteEnableA,
  input  logic [$clog2(nrOfEntries)-1:0] addressA,
  input  logic [bitwidth-1:0]            dataInA,
  output logic [bitwidth-1:0]            dataOutA,
  output logic                           dataValidA,
  input  logic                           requestB,
  input  logic                           writeEnableB,
  input  logic [bitwidth/8-1:0]          byteEnableB,
  input  logic [$clog2(nrOfEntries)-1:0] addressB,
  input  logic [bitwidth-1:0]            dataInB,
  output logic [bitwidth-1:0]            dataOutB,
  output logic                           dataValidB,
  output logic                           collision
);
  localparam int AW = $clog2(nrOfEntries);
  localparam int NB = bitwidth / 8;
  localparam logic [AW-1:0] LAST = AW'(nrOfEntries - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [bitwidth-1:0] mem [nrOfEntries];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      READY: begin
        if (clearRequest) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy = reset | (state == CLEAR);

  logic ready, acc_a, acc_b, wr_a, wr_b, same;
  logic [bitwidth-1:0] old_a, old_b, new_a, new_b;

  assign ready = (state == READY) & ~reset;
  assign acc_a = ready & requestA;
  assign acc_b = ready & requestB;
  assign wr_a  = acc_a & writeEnableA;
  assign wr_b  = acc_b & writeEnableB;
  assign same  = (addressA == addressB);
  assign old_a = mem[addressA];
  assign old_b = mem[addressB];

  // Post-write word seen at each address; on a shared address both views are
  // identical, with A's enabled bytes taking priority over B's.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && byteEnableA[i])              new_a[8*i +: 8] = dataInA[8*i +: 8];
      else if (wr_b && same && byteEnableB[i]) new_a[8*i +: 8] = dataInB[8*i +: 8];
      if (wr_a && same && byteEnableA[i])      new_b[8*i +: 8] = dataInA[8*i +: 8];
      else if (wr_b && byteEnableB[i])         new_b[8*i +: 8] = dataInB[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (wr_b) mem[addressB] <= new_b;
        if (wr_a) mem[addressA] <= new_a;
      end
    end
  end

  logic [bitwidth-1:0] rd_a, rd_b, s_da, s_db;
  logic                col, s_va, s_vb, s_col;

  assign rd_a = (readMode != 0) ? new_a : old_a;
  assign rd_b = (readMode != 0) ? new_b : old_b;
  assign col  = wr_a & wr_b & same;

  generate
    if (outputRegister != 0) begin : g_oreg
      logic [bitwidth-1:0] p_da, p_db;
      logic                p_va, p_vb, p_col;
      always_ff @(posedge clock) begin
        if (reset) begin
          p_va  <= 1'b0;
          p_vb  <= 1'b0;
          p_col <= 1'b0;
          p_da  <= '0;
          p_db  <= '0;
        end else begin
          p_va  <= acc_a;
          p_vb  <= acc_b;
          p_col <= col;
          p_da  <= rd_a;
          p_db  <= rd_b;
        end
      end
      assign s_va  = p_va;
      assign s_vb  = p_vb;
      assign s_col = p_col;
      assign s_da  = p_da;
      assign s_db  = p_db;
    end else begin : g_noreg
      assign s_va  = acc_a;
      assign s_vb  = acc_b;
      assign s_col = col;
      assign s_da  = rd_a;
      assign s_db  = rd_b;
    end
  endgenerate

  // Data outputs only move on a valid beat so they hold between accesses.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataValidA <= 1'b0;
      dataValidB <= 1'b0;
      collision  <= 1'b0;
      dataOutA   <= '0;
      dataOutB   <= '0;
    end else begin
      dataValidA <= s_va;
      dataValidB <= s_vb;
      collision  <= s_col;
      if (s_va) dataOutA <= s_da;
      if (s_vb) dataOutB <= s_db;
    end
  end

endmodule
